// File: rtl/rgmiiulator_pkg.sv
// Shared constants and state encodings for the MII sniffer.
// Holds the receive and UART FSM state types.
package rgmiiulator_pkg;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_8n1.sv
// UART 8N1 transmitter. Accepts a byte on valid&&ready and shifts it out
// LSB first; ready is raised in the last stop-bit cycle so bytes go back to back.
module uart_tx_8n1
    import rgmiiulator_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       SW0,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;

    always_ff @(posedge clk or negedge SW0) begin
        if (!SW0) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    // tx decodes straight from the async-reset state, so reset idles the line at once.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        ready     = 1'b0;
        tx        = 1'b1;
        case (state)
            TX_IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    shreg_n = data;
                    cnt_n   = '0;
                    state_n = TX_START;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (cnt == LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = TX_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            TX_DATA: begin
                tx = shreg[0];
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = TX_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            TX_STOP: begin
                tx = 1'b1;
                if (cnt == LAST) begin
                    ready = 1'b1;
                    cnt_n = '0;
                    if (valid) begin
                        shreg_n = data;
                        state_n = TX_START;
                    end else begin
                        state_n = TX_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = TX_IDLE;
        endcase
    end

endmodule

// File: rtl/rgmiiulator_top.sv
// MII sniffer top: oversamples the MII RX pins, strips preamble/SFD, packs
// nibbles into bytes, buffers them in a FIFO and streams them out over UART.
module rgmiiulator_top
    import rgmiiulator_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic       clk,
    input  logic       SW0,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] LED,
    input  logic       rgm0_en,
    input  logic       rgm0_clk,
    input  logic [3:0] rgm0_d
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic unused_uart_rx;
    assign unused_uart_rx = uart_rx;

    // Two flops on every pin; the third clk flop only remembers the previous level.
    logic [2:0] clk_sync;
    logic [1:0] en_sync;
    logic [3:0] d_s1, d_s2;

    always_ff @(posedge clk or negedge SW0) begin
        if (!SW0) begin
            clk_sync <= '0;
            en_sync  <= '0;
            d_s1     <= '0;
            d_s2     <= '0;
        end else begin
            clk_sync <= {clk_sync[1:0], rgm0_clk};
            en_sync  <= {en_sync[0], rgm0_en};
            d_s1     <= rgm0_d;
            d_s2     <= d_s1;
        end
    end

    logic       tick;
    logic       en_s;
    logic [3:0] d_s;
    assign tick = clk_sync[1] & ~clk_sync[2];
    assign en_s = en_sync[1];
    assign d_s  = d_s2;

    rx_state_t  rx_state, rx_state_n;
    logic [7:0] byte_cnt, byte_cnt_n;
    logic       half, half_n;
    logic [3:0] lo_nib, lo_nib_n;
    logic       push_valid, push_valid_n;
    logic [7:0] push_data, push_data_n;
    logic [7:0] led_q, led_n;

    always_ff @(posedge clk or negedge SW0) begin
        if (!SW0) begin
            rx_state   <= IDLE;
            byte_cnt   <= '0;
            half       <= 1'b0;
            lo_nib     <= '0;
            push_valid <= 1'b0;
            push_data  <= '0;
            led_q      <= '0;
        end else begin
            rx_state   <= rx_state_n;
            byte_cnt   <= byte_cnt_n;
            half       <= half_n;
            lo_nib     <= lo_nib_n;
            push_valid <= push_valid_n;
            push_data  <= push_data_n;
            led_q      <= led_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        byte_cnt_n   = byte_cnt;
        half_n       = half;
        lo_nib_n     = lo_nib;
        push_valid_n = 1'b0;
        push_data_n  = push_data;
        led_n        = led_q;
        if (tick) begin
            case (rx_state)
                IDLE: begin
                    if (en_s && d_s == PREAMBLE_NIB) rx_state_n = PRE;
                end
                PRE: begin
                    if (!en_s) begin
                        rx_state_n = IDLE;
                    end else if (d_s == SFD_NIB) begin
                        rx_state_n = DATA;
                        byte_cnt_n = '0;
                        half_n     = 1'b0;
                    end else if (d_s != PREAMBLE_NIB) begin
                        rx_state_n = DROP;
                    end
                end
                DATA: begin
                    if (!en_s) begin
                        led_n      = byte_cnt;
                        rx_state_n = IDLE;
                    end else if (!half) begin
                        lo_nib_n = d_s;
                        half_n   = 1'b1;
                    end else begin
                        half_n       = 1'b0;
                        push_valid_n = 1'b1;
                        push_data_n  = {d_s, lo_nib};
                        if (byte_cnt != 8'hFF) byte_cnt_n = byte_cnt + 8'd1;
                    end
                end
                DROP: begin
                    if (!en_s) rx_state_n = IDLE;
                end
                default: rx_state_n = IDLE;
            endcase
        end
    end

    assign LED = led_q;

    // FIFO -> UART handshake: a byte moves on any cycle where valid (FIFO
    // non-empty) and ready (transmitter can load) are both high; data is held
    // stable until then, and valid never depends on ready.
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push, tx_ready;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && tx_ready;
    assign push  = push_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge SW0) begin
        if (!SW0) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .SW0  (SW0),
        .data (mem[rd_ptr[AW-1:0]]),
        .valid(!empty),
        .ready(tx_ready),
        .tx   (uart_tx)
    );

endmodule

// File: tb/tb_rgmiiulator_top.sv
// Bench for the MII sniffer: drives MII frames, decodes the UART line and
// compares bytes and LED against a frame-level reference model.
`timescale 1ns/1ps
module tb_rgmiiulator_top;

    localparam int CPB   = 16;
    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       SW0 = 1'b0;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [7:0] LED;
    logic       rgm0_en = 1'b0;
    logic       rgm0_clk = 1'b0;
    logic [3:0] rgm0_d = 4'h0;

    always #10 clk = ~clk;

    rgmiiulator_top #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .SW0(SW0), .uart_rx(uart_rx), .uart_tx(uart_tx), .LED(LED),
        .rgm0_en(rgm0_en), .rgm0_clk(rgm0_clk), .rgm0_d(rgm0_d)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [3:0] frame_q[$];
    int         start_q[$];
    logic [7:0] led_model = 8'h00;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // UART line decoder, sampling mid-bit on the falling clock edge.
    bit         mon_busy = 1'b0;
    int         mon_t = 0;
    logic [7:0] mon_byte;
    always @(negedge clk) begin
        if (SW0 !== 1'b1) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_t = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t == CPB / 2) begin
                check("uart_start_bit", {31'd0, uart_tx}, 32'd0);
            end else if (mon_t > CPB / 2 && ((mon_t - CPB / 2) % CPB) == 0) begin
                int k;
                k = (mon_t - CPB / 2) / CPB;
                if (k <= 8) begin
                    mon_byte[k-1] = uart_tx;
                end else begin
                    check("uart_stop_bit", {31'd0, uart_tx}, 32'd1);
                    got_q.push_back(mon_byte);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    // Frame-level model: skip to the first preamble nibble, skip the preamble
    // run, require SFD, then pair the remaining nibbles low-first.
    function automatic int model_frame();
        int p, n, nbytes;
        p = 0;
        while (p < frame_q.size() && frame_q[p] != 4'h5) p++;
        if (p == frame_q.size()) return 0;
        while (p < frame_q.size() && frame_q[p] == 4'h5) p++;
        if (p == frame_q.size() || frame_q[p] != 4'hD) return 0;
        n = frame_q.size() - p - 1;
        nbytes = n / 2;
        for (int k = 0; k < nbytes; k++)
            exp_q.push_back({frame_q[p + 2 + 2 * k], frame_q[p + 1 + 2 * k]});
        led_model = (nbytes > 255) ? 8'hFF : 8'(nbytes);
        return nbytes;
    endfunction

    task automatic send_nib(input logic en, input logic [3:0] d);
        @(negedge clk);
        rgm0_clk = 1'b0;
        rgm0_en  = en;
        rgm0_d   = d;
        @(negedge clk);
        rgm0_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [3:0] term_d);
        foreach (frame_q[i]) send_nib(1'b1, frame_q[i]);
        send_nib(1'b0, term_d);
        send_nib(1'b0, 4'h0);
        send_nib(1'b0, 4'h0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        frame_q.push_back(b[3:0]);
        frame_q.push_back(b[7:4]);
    endtask

    task automatic push_pre(input int n);
        for (int i = 0; i < n; i++) frame_q.push_back(4'h5);
    endtask

    task automatic drain();
        int quiet, n;
        quiet = 0;
        n = 0;
        repeat (20) @(negedge clk);
        while (quiet < 200 && n < 20000) begin
            @(negedge clk);
            n++;
            if (uart_tx === 1'b1 && !mon_busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: uart still active after %0d cycles, required idle", n);
        end
    endtask

    task automatic compare_bytes(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({name, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    endtask

    typedef struct {
        int         n_garb;
        int         n_pre;
        logic [3:0] sfd;
        int         n_data;
        int         exp_bytes;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, lows, bad;
        logic [3:0] v;
        logic [7:0] hand[8];

        // Reset and quiet line.
        SW0 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_led", {24'd0, LED}, 32'd0);
        SW0 = 1'b1;
        lows = 0;
        repeat (500) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("idle_tx_low_cycles", lows, 0);
        check("idle_no_bytes", got_q.size(), 0);

        // Table of frame shapes; data nibbles are random.
        vecs[0] = '{0, 15, 4'hD, 8, 4, 8'h04};
        vecs[1] = '{3,  7, 4'hD, 7, 3, 8'h03};
        vecs[2] = '{0,  2, 4'h7, 6, 0, 8'h03};
        vecs[3] = '{0,  1, 4'hD, 3, 1, 8'h01};
        vecs[4] = '{2,  4, 4'hD, 0, 0, 8'h00};
        vecs[5] = '{0,  3, 4'h5, 0, 0, 8'h00};
        for (int r = 0; r < 6; r++) begin
            frame_q.delete(); exp_q.delete(); got_q.delete();
            for (int i = 0; i < vecs[r].n_garb; i++) begin
                do v = 4'($urandom_range(0, 15)); while (v == 4'h5);
                frame_q.push_back(v);
            end
            push_pre(vecs[r].n_pre);
            frame_q.push_back(vecs[r].sfd);
            for (int i = 0; i < vecs[r].n_data; i++) frame_q.push_back(4'($urandom_range(0, 15)));
            void'(model_frame());
            send_frame(4'h0);
            drain();
            check("vec_led", {24'd0, LED}, {24'd0, vecs[r].exp_led});
            check("vec_nbytes", got_q.size(), vecs[r].exp_bytes);
            compare_bytes("vec");
        end

        // Nominal frame; en drops together with the final CRC nibble.
        frame_q.delete(); exp_q.delete(); got_q.delete(); start_q.delete();
        frame_q.push_back(4'h0);
        push_pre(15);
        frame_q.push_back(4'hD);
        push_byte(8'h54); push_byte(8'hff); push_byte(8'h01); push_byte(8'h21);
        push_byte(8'h23); push_byte(8'h24); push_byte(8'h12); push_byte(8'h34);
        push_byte(8'h56); push_byte(8'h78); push_byte(8'h9a); push_byte(8'hbc);
        push_byte(8'h12); push_byte(8'h34);
        for (int i = 0; i < 32; i++) push_byte(8'(i * 7 + 3));
        push_byte(8'hfb); push_byte(8'h02); push_byte(8'h90);
        frame_q.push_back(4'h4);
        void'(model_frame());
        send_frame(4'h6);
        drain();
        hand = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24, 8'h12, 8'h34};
        check("nom_led", {24'd0, LED}, 32'h31);
        check("nom_nbytes", got_q.size(), 49);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check("nom_head", {24'd0, got_q[i]}, {24'd0, hand[i]});
        compare_bytes("nom");
        bad = 0;
        for (int i = 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != CPB * 10) bad++;
        check("nom_b2b_gaps", bad, 0);

        // Odd nibble count.
        frame_q.delete(); exp_q.delete(); got_q.delete();
        push_pre(4);
        frame_q.push_back(4'hD);
        frame_q.push_back(4'h1); frame_q.push_back(4'h2); frame_q.push_back(4'h3);
        void'(model_frame());
        send_frame(4'h0);
        drain();
        check("odd_nbytes", got_q.size(), 1);
        if (got_q.size() > 0) check("odd_byte", {24'd0, got_q[0]}, 32'h21);
        check("odd_led", {24'd0, LED}, 32'h01);

        // Bad preamble.
        frame_q.delete(); exp_q.delete(); got_q.delete();
        frame_q.push_back(4'h5); frame_q.push_back(4'h5); frame_q.push_back(4'h7);
        for (int i = 0; i < 10; i++) frame_q.push_back(4'($urandom_range(0, 15)));
        void'(model_frame());
        send_frame(4'h0);
        drain();
        check("badpre_nbytes", got_q.size(), 0);
        check("badpre_led", {24'd0, LED}, 32'h01);

        // Overflow: 80 distinct bytes arrive far faster than the UART drains.
        frame_q.delete(); exp_q.delete(); got_q.delete();
        push_pre(15);
        frame_q.push_back(4'hD);
        for (int i = 0; i < 80; i++) push_byte(8'(i));
        void'(model_frame());
        send_frame(4'h0);
        drain();
        check("ovf_led", {24'd0, LED}, 32'h50);
        check("ovf_count_ge_depth", {31'd0, got_q.size() >= DEPTH}, 32'd1);
        check("ovf_some_dropped", {31'd0, got_q.size() < 80}, 32'd1);
        for (int i = 0; i < DEPTH && i < got_q.size(); i++)
            check("ovf_prefix", {24'd0, got_q[i]}, i);
        bad = 0;
        for (int i = 1; i < got_q.size(); i++)
            if (got_q[i] <= got_q[i-1]) bad++;
        check("ovf_order", bad, 0);

        // Byte count saturation.
        frame_q.delete(); exp_q.delete(); got_q.delete();
        push_pre(7);
        frame_q.push_back(4'hD);
        for (int i = 0; i < 300; i++) push_byte(8'($urandom_range(0, 255)));
        void'(model_frame());
        send_frame(4'h0);
        drain();
        check("sat_led", {24'd0, LED}, 32'hFF);

        // Random frames against the model.
        for (int f = 0; f < 8; f++) begin
            frame_q.delete(); exp_q.delete(); got_q.delete();
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                do v = 4'($urandom_range(0, 15)); while (v == 4'h5);
                frame_q.push_back(v);
            end
            push_pre($urandom_range(1, 8));
            frame_q.push_back(($urandom_range(0, 4) != 0) ? 4'hD : 4'($urandom_range(0, 15)));
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) frame_q.push_back(4'($urandom_range(0, 15)));
            void'(model_frame());
            send_frame(4'($urandom_range(0, 15)));
            drain();
            check("rand_led", {24'd0, LED}, {24'd0, led_model});
            compare_bytes("rand");
        end

        // Reset in the middle of a UART byte.
        frame_q.delete(); exp_q.delete(); got_q.delete();
        push_pre(6);
        frame_q.push_back(4'hD);
        push_byte(8'hA5); push_byte(8'h3C); push_byte(8'h0F);
        void'(model_frame());
        send_frame(4'h0);
        check("prerst_led", {24'd0, LED}, 32'h03);
        n = 0;
        while (uart_tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("prerst_tx_started", {31'd0, uart_tx}, 32'd0);
        repeat (3) @(negedge clk);
        #3 SW0 = 1'b0;
        #1;
        check("rst_tx_immediate", {31'd0, uart_tx}, 32'd1);
        check("rst_led_immediate", {24'd0, LED}, 32'd0);
        repeat (5) @(negedge clk);
        SW0 = 1'b1;
        led_model = 8'h00;
        got_q.delete(); exp_q.delete();
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("postrst_fifo_empty", got_q.size(), 0);
        check("postrst_tx_idle", lows, 0);
        check("postrst_led", {24'd0, LED}, 32'd0);

        // Recovery after reset.
        frame_q.delete(); exp_q.delete(); got_q.delete();
        push_pre(5);
        frame_q.push_back(4'hD);
        push_byte(8'h81); push_byte(8'h7E);
        void'(model_frame());
        send_frame(4'h0);
        drain();
        check("recov_led", {24'd0, LED}, 32'h02);
        compare_bytes("recov");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
